// File: rtl/quick_spi_burst_arbiter.sv
// Round-robin arbiter sharing one quick_spi byte engine between N_REQ requesters.
// Each grant runs a chip-select framed burst of len+1 bytes with setup/hold spacing and a byte timeout.
module quick_spi_burst_arbiter #(
  parameter int N_REQ    = 2,
  parameter int LEN_W    = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int TIMEOUT  = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*LEN_W-1:0] len,
  input  logic [N_REQ*8-1:0]     tx_data,
  output logic [N_REQ-1:0]       tx_ack,
  output logic [7:0]             rx_data,
  output logic [N_REQ-1:0]       rx_valid,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic [N_REQ-1:0]       err,
  output logic [N_REQ-1:0]       cs_n,
  output logic                   spi_start,
  output logic [7:0]             spi_data_in,
  input  logic                   spi_busy,
  input  logic                   spi_new_data,
  input  logic [7:0]             spi_data_out
);
  localparam int IDX_W   = (N_REQ > 2) ? 2 : 1;
  localparam int DLY_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int DLY_W   = $clog2(DLY_MAX + 1);
  localparam int TMR_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_LOAD, S_WAIT, S_HOLD} state_t;

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_ptr, w_ptr_nxt;
  logic [IDX_W-1:0]   r_own, w_own_nxt;
  logic [LEN_W-1:0]   r_cnt, w_cnt_nxt;
  logic [DLY_W-1:0]   r_dly, w_dly_nxt;
  logic [TMR_W-1:0]   r_timer, w_timer_nxt;
  logic               r_abort, w_abort_nxt;
  logic [N_REQ-1:0]   r_gnt, w_gnt_nxt;
  logic [N_REQ-1:0]   r_cs_n, w_cs_n_nxt;
  logic               r_start, w_start_nxt;
  logic [7:0]         r_sdi, w_sdi_nxt;
  logic [7:0]         r_rx_data, w_rx_data_nxt;
  logic [N_REQ-1:0]   r_rx_valid, w_rx_valid_nxt;
  logic [N_REQ-1:0]   r_tx_ack, w_tx_ack_nxt;
  logic [N_REQ-1:0]   r_done, w_done_nxt;
  logic [N_REQ-1:0]   r_err, w_err_nxt;

  logic               w_any;
  logic [IDX_W-1:0]   w_win;
  logic [IDX_W-1:0]   w_cand;
  logic [N_REQ-1:0]   w_win_oh;
  logic [N_REQ-1:0]   w_own_oh;
  logic               w_end;
  logic               w_finish;

  // Descending scan so the nearest requester after the pointer wins.
  always_comb begin
    w_any  = 1'b0;
    w_win  = '0;
    w_cand = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      w_cand = IDX_W'((int'(r_ptr) + i) % N_REQ);
      if (req[w_cand]) begin
        w_any = 1'b1;
        w_win = w_cand;
      end
    end
  end

  assign w_win_oh = {{(N_REQ-1){1'b0}}, 1'b1} << w_win;
  assign w_own_oh = {{(N_REQ-1){1'b0}}, 1'b1} << r_own;

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_own_nxt      = r_own;
    w_cnt_nxt      = r_cnt;
    w_dly_nxt      = r_dly;
    w_timer_nxt    = r_timer;
    w_abort_nxt    = r_abort;
    w_gnt_nxt      = r_gnt;
    w_cs_n_nxt     = r_cs_n;
    w_start_nxt    = 1'b0;
    w_sdi_nxt      = r_sdi;
    w_rx_data_nxt  = r_rx_data;
    w_rx_valid_nxt = '0;
    w_tx_ack_nxt   = '0;
    w_done_nxt     = '0;
    w_err_nxt      = '0;
    w_end          = 1'b0;
    w_finish       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_ptr_nxt   = w_win;
          w_own_nxt   = w_win;
          w_gnt_nxt   = w_win_oh;
          w_cs_n_nxt  = ~w_win_oh;
          w_cnt_nxt   = len[int'(w_win)*LEN_W +: LEN_W];
          w_abort_nxt = 1'b0;
          w_dly_nxt   = '0;
          // The LOAD cycle itself supplies the last setup cycle.
          w_state_nxt = (CS_SETUP > 1) ? S_SETUP : S_LOAD;
        end
      end
      S_SETUP: begin
        w_dly_nxt = r_dly + DLY_W'(1);
        if (int'(r_dly) >= CS_SETUP - 2) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (!spi_busy) begin
          w_start_nxt  = 1'b1;
          w_sdi_nxt    = tx_data[int'(r_own)*8 +: 8];
          w_tx_ack_nxt = w_own_oh;
          w_timer_nxt  = '0;
          w_state_nxt  = S_WAIT;
        end
      end
      S_WAIT: begin
        w_timer_nxt = r_timer + TMR_W'(1);
        if (spi_new_data) begin
          w_rx_data_nxt  = spi_data_out;
          w_rx_valid_nxt = w_own_oh;
          if (r_cnt == '0) begin
            w_end = 1'b1;
          end else begin
            w_cnt_nxt   = r_cnt - LEN_W'(1);
            w_state_nxt = S_LOAD;
          end
        end else if (r_timer == TMR_W'(TIMEOUT)) begin
          w_abort_nxt = 1'b1;
          w_end       = 1'b1;
        end
        if (w_end) begin
          w_dly_nxt = '0;
          if (CS_HOLD > 1) w_state_nxt = S_HOLD;
          else             w_finish    = 1'b1;
        end
      end
      S_HOLD: begin
        w_dly_nxt = r_dly + DLY_W'(1);
        if (int'(r_dly) >= CS_HOLD - 2) w_finish = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_finish) begin
      w_cs_n_nxt  = '1;
      w_gnt_nxt   = '0;
      w_done_nxt  = w_own_oh;
      w_err_nxt   = w_abort_nxt ? w_own_oh : '0;
      w_state_nxt = S_IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= IDX_W'(N_REQ - 1);
      r_own      <= '0;
      r_cnt      <= '0;
      r_dly      <= '0;
      r_timer    <= '0;
      r_abort    <= 1'b0;
      r_gnt      <= '0;
      r_cs_n     <= '1;
      r_start    <= 1'b0;
      r_sdi      <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= '0;
      r_tx_ack   <= '0;
      r_done     <= '0;
      r_err      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_own      <= w_own_nxt;
      r_cnt      <= w_cnt_nxt;
      r_dly      <= w_dly_nxt;
      r_timer    <= w_timer_nxt;
      r_abort    <= w_abort_nxt;
      r_gnt      <= w_gnt_nxt;
      r_cs_n     <= w_cs_n_nxt;
      r_start    <= w_start_nxt;
      r_sdi      <= w_sdi_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_rx_valid <= w_rx_valid_nxt;
      r_tx_ack   <= w_tx_ack_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign gnt         = r_gnt;
  assign cs_n        = r_cs_n;
  assign spi_start   = r_start;
  assign spi_data_in = r_sdi;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign tx_ack      = r_tx_ack;
  assign done        = r_done;
  assign err         = r_err;

endmodule

// File: tb/tb_quick_spi_burst_arbiter.sv
// Scoreboard bench for quick_spi_burst_arbiter with a looped-back behavioural quick_spi model.
module tb_quick_spi_burst_arbiter;
  localparam int N_REQ    = 2;
  localparam int LEN_W    = 4;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int TIMEOUT  = 255;
  localparam int CLK_DIV  = 2;
  localparam int BUDGET   = 1500;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } rx_exp_t;

  typedef struct {
    logic [N_REQ-1:0] d;
    logic [N_REQ-1:0] e;
  } done_exp_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*LEN_W-1:0] len;
  logic [N_REQ*8-1:0]     tx_data;
  logic [N_REQ-1:0]       tx_ack;
  logic [7:0]             rx_data;
  logic [N_REQ-1:0]       rx_valid;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       done;
  logic [N_REQ-1:0]       err;
  logic [N_REQ-1:0]       cs_n;
  logic                   spi_start;
  logic [7:0]             spi_data_in;
  logic                   spi_busy;
  logic                   spi_new_data;
  logic [7:0]             spi_data_out;

  quick_spi_burst_arbiter #(
    .N_REQ(N_REQ), .LEN_W(LEN_W), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .len(len), .tx_data(tx_data), .tx_ack(tx_ack),
    .rx_data(rx_data), .rx_valid(rx_valid), .gnt(gnt), .done(done), .err(err), .cs_n(cs_n),
    .spi_start(spi_start), .spi_data_in(spi_data_in), .spi_busy(spi_busy),
    .spi_new_data(spi_new_data), .spi_data_out(spi_data_out)
  );

  always #25 clk = ~clk;

  // Behavioural quick_spi: 8 bits at 2^CLK_DIV clocks each, MISO looped to MOSI.
  logic       mute;
  logic [7:0] m_shift;
  int         m_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      spi_busy     <= 1'b0;
      spi_new_data <= 1'b0;
      spi_data_out <= 8'h00;
      m_shift      <= 8'h00;
      m_cnt        <= 0;
    end else begin
      spi_new_data <= 1'b0;
      if (!spi_busy) begin
        if (spi_start) begin
          spi_busy <= 1'b1;
          m_shift  <= spi_data_in;
          m_cnt    <= 8 * (1 << CLK_DIV) - 1;
        end
      end else if (m_cnt == 0) begin
        spi_busy <= 1'b0;
        if (!mute) begin
          spi_new_data <= 1'b1;
          spi_data_out <= m_shift;
        end
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // Per-requester byte source advanced on every tx_ack.
  logic [7:0] tx_mem [N_REQ][16];
  int         tx_ptr [N_REQ];
  for (genvar g = 0; g < N_REQ; g++) begin : g_tx
    assign tx_data[g*8 +: 8] = tx_mem[g][tx_ptr[g]];
  end

  initial begin
    for (int i = 0; i < N_REQ; i++) tx_ptr[i] = 0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N_REQ; i++)
        if (tx_ack[i]) tx_ptr[i] = (tx_ptr[i] + 1) & 15;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  rx_exp_t   exp_rx[$];
  done_exp_t exp_done[$];
  logic [N_REQ-1:0] grant_log[$];

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int n_start = 0;
  int n_done  = 0;
  int n_ack  [N_REQ];
  int n_fall [N_REQ];
  int start_cyc, nd_cyc, fall_cyc, done_cyc;
  int setup_meas, hold_meas;
  logic setup_pend  = 1'b0;
  logic cs_bad      = 1'b0;
  logic overlap_bad = 1'b0;
  logic gap_bad     = 1'b0;
  logic [N_REQ-1:0] prev_cs_n = '1;
  logic [N_REQ-1:0] prev_gnt  = '0;
  rx_exp_t   mon_rx;
  done_exp_t mon_done;

  // Monitor: samples on the falling edge and scores every rx_valid/done against the queues.
  initial begin
    for (int i = 0; i < N_REQ; i++) begin
      n_ack[i]  = 0;
      n_fall[i] = 0;
    end
    forever begin
      @(negedge clk);
      if (spi_start) begin
        n_start++;
        start_cyc = cyc;
        if (setup_pend) begin
          setup_meas = cyc - fall_cyc;
          setup_pend = 1'b0;
        end
      end
      if (spi_new_data) nd_cyc = cyc;
      for (int i = 0; i < N_REQ; i++) begin
        if (tx_ack[i]) n_ack[i]++;
        if (!cs_n[i] && prev_cs_n[i]) begin
          n_fall[i]++;
          fall_cyc   = cyc;
          setup_pend = 1'b1;
        end
      end
      if ((spi_start || tx_ack != '0 || rx_valid != '0) && (gnt == '0 || cs_n != ~gnt)) cs_bad = 1'b1;
      if ($countones(~cs_n) > 1) overlap_bad = 1'b1;
      if ((done != '0 && gnt != '0) || (gnt != '0 && prev_gnt != '0 && gnt != prev_gnt)) gap_bad = 1'b1;
      if (gnt != '0 && prev_gnt == '0) grant_log.push_back(gnt);
      if (rx_valid != '0) begin
        if (exp_rx.size() == 0) begin
          check("rx_unexpected", rx_valid, 0);
        end else begin
          mon_rx = exp_rx.pop_front();
          check("rx_owner", rx_valid, 1 << mon_rx.idx);
          check("rx_data", rx_data, mon_rx.data);
        end
      end
      if (err != '0 && done == '0) check("err_without_done", err, 0);
      if (done != '0) begin
        n_done++;
        done_cyc  = cyc;
        hold_meas = cyc - nd_cyc;
        if (exp_done.size() == 0) begin
          check("done_unexpected", done, 0);
        end else begin
          mon_done = exp_done.pop_front();
          check("done_vec", done, mon_done.d);
          check("err_vec", err, mon_done.e);
        end
      end
      prev_cs_n = cs_n;
      prev_gnt  = gnt;
    end
  end

  task automatic push_rx(input int idx, input logic [7:0] d);
    rx_exp_t e;
    e.idx  = idx;
    e.data = d;
    exp_rx.push_back(e);
  endtask

  task automatic push_done(input logic [N_REQ-1:0] d, input logic [N_REQ-1:0] e);
    done_exp_t x;
    x.d = d;
    x.e = e;
    exp_done.push_back(x);
  endtask

  task automatic load_tx(input int i, input int n, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] b [4];
    b = '{b0, b1, b2, b3};
    for (int k = 0; k < n; k++) tx_mem[i][(tx_ptr[i] + k) & 15] = b[k];
  endtask

  task automatic set_len(input int i, input int v);
    len[i*LEN_W +: LEN_W] = LEN_W'(v);
  endtask

  task automatic wait_gnt(input string name);
    int k = 0;
    while (gnt == '0 && k < BUDGET) begin
      @(negedge clk);
      k++;
    end
    check({name, "_gnt_seen"}, gnt != '0, 1);
  endtask

  task automatic wait_done(input int target, input string name);
    int k = 0;
    while (n_done < target && k < BUDGET) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    check({name, "_done_count"}, n_done, target);
  endtask

  int b_start, b_done;
  int b_ack [N_REQ];
  int b_fall[N_REQ];

  task automatic snap();
    b_start = n_start;
    b_done  = n_done;
    for (int i = 0; i < N_REQ; i++) begin
      b_ack[i]  = n_ack[i];
      b_fall[i] = n_fall[i];
    end
    cs_bad = 1'b0;
  endtask

  initial begin
    int k;
    int acks;
    rst  = 1'b1;
    req  = '0;
    len  = '0;
    mute = 1'b0;
    for (int i = 0; i < N_REQ; i++)
      for (int j = 0; j < 16; j++) tx_mem[i][j] = 8'h00;

    #1;
    check("rst_gnt", gnt, 0);
    check("rst_cs_n", cs_n, 2'b11);
    check("rst_spi_start", spi_start, 0);
    check("rst_spi_data_in", spi_data_in, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_pulses", {tx_ack, rx_valid, done, err}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_cs_n", cs_n, 2'b11);
    check("idle_gnt", gnt, 0);

    // 1: single byte from requester 0
    snap();
    set_len(0, 0);
    load_tx(0, 1, 8'h6C, 8'h00, 8'h00, 8'h00);
    push_rx(0, 8'h6C);
    push_done(2'b01, 2'b00);
    req = 2'b01;
    wait_gnt("t1");
    req = 2'b00;
    wait_done(b_done + 1, "t1");
    check("t1_acks", n_ack[0] - b_ack[0], 1);
    check("t1_starts", n_start - b_start, 1);
    check("t1_cs_windows", n_fall[0] - b_fall[0], 1);
    check("t1_other_cs", n_fall[1] - b_fall[1], 0);
    check("t1_setup_cycles", setup_meas, CS_SETUP);
    check("t1_hold_cycles", hold_meas, CS_HOLD);
    check("t1_cs_owner", cs_bad, 0);
    check("t1_rx_drained", exp_rx.size(), 0);
    check("t1_cs_released", cs_n, 2'b11);

    // 2: four-byte burst from requester 1
    snap();
    set_len(1, 3);
    load_tx(1, 4, 8'hA5, 8'h3C, 8'hFF, 8'h00);
    push_rx(1, 8'hA5);
    push_rx(1, 8'h3C);
    push_rx(1, 8'hFF);
    push_rx(1, 8'h00);
    push_done(2'b10, 2'b00);
    req = 2'b10;
    wait_gnt("t2");
    req = 2'b00;
    wait_done(b_done + 1, "t2");
    check("t2_acks", n_ack[1] - b_ack[1], 4);
    check("t2_starts", n_start - b_start, 4);
    check("t2_cs_windows", n_fall[1] - b_fall[1], 1);
    check("t2_cs_owner", cs_bad, 0);
    check("t2_rx_drained", exp_rx.size(), 0);

    // 3: both requesters held, two-byte bursts alternate
    snap();
    grant_log.delete();
    set_len(0, 1);
    set_len(1, 1);
    load_tx(0, 4, 8'h11, 8'h22, 8'h33, 8'h44);
    load_tx(1, 4, 8'h55, 8'h66, 8'h77, 8'h88);
    push_rx(0, 8'h11); push_rx(0, 8'h22);
    push_rx(1, 8'h55); push_rx(1, 8'h66);
    push_rx(0, 8'h33); push_rx(0, 8'h44);
    push_rx(1, 8'h77); push_rx(1, 8'h88);
    push_done(2'b01, 2'b00); push_done(2'b10, 2'b00);
    push_done(2'b01, 2'b00); push_done(2'b10, 2'b00);
    req = 2'b11;
    k = 0;
    while (grant_log.size() < 4 && k < 4 * BUDGET) begin
      @(negedge clk);
      k++;
    end
    req = 2'b00;
    wait_done(b_done + 4, "t3");
    check("t3_grant_count", grant_log.size(), 4);
    check("t3_grant0", grant_log[0], 2'b01);
    check("t3_grant1", grant_log[1], 2'b10);
    check("t3_grant2", grant_log[2], 2'b01);
    check("t3_grant3", grant_log[3], 2'b10);
    check("t3_cs_windows0", n_fall[0] - b_fall[0], 2);
    check("t3_cs_windows1", n_fall[1] - b_fall[1], 2);
    check("t3_starts", n_start - b_start, 8);
    check("t3_rx_drained", exp_rx.size(), 0);

    // 4: engine never completes -> timeout abort, then requester 1 served normally
    snap();
    mute = 1'b1;
    set_len(0, 0);
    load_tx(0, 1, 8'h99, 8'h00, 8'h00, 8'h00);
    push_done(2'b01, 2'b01);
    req = 2'b01;
    wait_gnt("t4");
    req = 2'b00;
    wait_done(b_done + 1, "t4");
    check("t4_abort_latency", done_cyc - start_cyc, TIMEOUT + CS_HOLD);
    check("t4_starts", n_start - b_start, 1);
    check("t4_cs_released", cs_n, 2'b11);
    mute = 1'b0;
    snap();
    set_len(1, 0);
    load_tx(1, 1, 8'h5A, 8'h00, 8'h00, 8'h00);
    push_rx(1, 8'h5A);
    push_done(2'b10, 2'b00);
    req = 2'b10;
    wait_gnt("t4b");
    req = 2'b00;
    wait_done(b_done + 1, "t4b");
    check("t4b_rx_drained", exp_rx.size(), 0);

    // 5: reset while the second byte of a four-byte burst starts
    snap();
    set_len(0, 3);
    load_tx(0, 4, 8'hA1, 8'hB2, 8'hC3, 8'hD4);
    push_rx(0, 8'hA1);
    req  = 2'b01;
    acks = 0;
    k    = 0;
    while (acks < 2 && k < BUDGET) begin
      @(negedge clk);
      if (tx_ack[0]) acks++;
      k++;
    end
    check("t5_second_ack_seen", acks, 2);
    req = 2'b00;
    #5 rst = 1'b1;
    #1;
    check("t5_rst_cs_n", cs_n, 2'b11);
    check("t5_rst_spi_start", spi_start, 0);
    check("t5_rst_gnt", gnt, 0);
    repeat (2) @(negedge clk);
    check("t5_rx_drained", exp_rx.size(), 0);
    check("t5_no_done", exp_done.size(), 0);
    snap();
    grant_log.delete();
    set_len(0, 0);
    set_len(1, 0);
    load_tx(0, 1, 8'hE1, 8'h00, 8'h00, 8'h00);
    load_tx(1, 1, 8'hE2, 8'h00, 8'h00, 8'h00);
    push_rx(0, 8'hE1);
    push_rx(1, 8'hE2);
    push_done(2'b01, 2'b00);
    push_done(2'b10, 2'b00);
    req = 2'b11;
    rst = 1'b0;
    k = 0;
    while (grant_log.size() < 2 && k < BUDGET) begin
      @(negedge clk);
      k++;
    end
    req = 2'b00;
    wait_done(b_done + 2, "t5");
    check("t5_first_grant", grant_log[0], 2'b01);
    check("t5_second_grant", grant_log[1], 2'b10);

    // 6: req dropped after first byte does not shorten the burst
    snap();
    set_len(0, 2);
    load_tx(0, 3, 8'h31, 8'h42, 8'h53, 8'h00);
    push_rx(0, 8'h31);
    push_rx(0, 8'h42);
    push_rx(0, 8'h53);
    push_done(2'b01, 2'b00);
    req = 2'b01;
    k = 0;
    while (!tx_ack[0] && k < BUDGET) begin
      @(negedge clk);
      k++;
    end
    req = 2'b00;
    wait_done(b_done + 1, "t6");
    check("t6_acks", n_ack[0] - b_ack[0], 3);
    check("t6_starts", n_start - b_start, 3);
    check("t6_cs_windows", n_fall[0] - b_fall[0], 1);
    check("t6_rx_drained", exp_rx.size(), 0);

    check("cs_never_overlap", overlap_bad, 0);
    check("idle_gap_between_bursts", gap_bad, 0);
    check("done_queue_drained", exp_done.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
